// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SLC-3 SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_LDR = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins outright, and a tie goes
// to the side that did not win last time.
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_id
);

    // Pure combinational pick; bit 0 is the CPU, bit 1 the loader.
    always_comb begin
        gnt_valid = |req;
        gnt_id    = last;
        case (req)
            2'b01:   gnt_id = GNT_CPU;
            2'b10:   gnt_id = GNT_LDR;
            2'b11:   gnt_id = ~last;
            default: gnt_id = last;
        endcase
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares the single SLC-3 SRAM between the CPU memory interface and the
// program loader. Each access is a fixed ACCESS_CYCLES-long SRAM cycle
// followed by a one-cycle done pulse to the owner. Every output is a flop.
//
//   state  | meaning
//   IDLE   | strobes off, sampling both requests for a new grant
//   ACCESS | address/data latched, ce_n plus oe_n or we_n low, cnt counting
//   DONE   | strobes off, owner's done high for this one cycle
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W        = 20,
    parameter int DATA_W        = 16,
    parameter int ACCESS_CYCLES = 3
) (
    input  logic              Clk,
    input  logic              Reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_done,

    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_done,

    output logic [DATA_W-1:0] rdata,

    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_wdata_en,
    input  logic [DATA_W-1:0] sram_rdata,

    output logic              busy,
    output logic              grant_id
);

    // Last count value of an access; ACCESS_CYCLES=1 makes this 0, so the
    // access ends on its first ACCESS cycle without the counter ever moving.
    localparam logic [3:0] CNT_LAST = 4'(ACCESS_CYCLES - 1);

    arb_state_t        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_we_q, owner_we_d;

    logic              cpu_done_d, ldr_done_d;
    logic [DATA_W-1:0] rdata_d;
    logic              sram_ce_n_d, sram_oe_n_d, sram_we_n_d;
    logic [ADDR_W-1:0] sram_addr_d;
    logic [DATA_W-1:0] sram_wdata_d;
    logic              sram_wdata_en_d;
    logic              busy_d, grant_id_d;

    logic              gnt_valid, gnt_id;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    rr_arb2 u_rr_arb2 (
        .req       ({ldr_req, cpu_req}),
        .last      (last_grant_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Select the winning requester's access fields for latching at grant.
    always_comb begin
        win_we    = cpu_we;
        win_addr  = cpu_addr;
        win_wdata = cpu_wdata;
        if (gnt_id == GNT_LDR) begin
            win_we    = ldr_we;
            win_addr  = ldr_addr;
            win_wdata = ldr_wdata;
        end
    end

    // Next-state and next-output logic; everything holds unless changed below.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        last_grant_d    = last_grant_q;
        owner_we_d      = owner_we_q;
        cpu_done_d      = 1'b0;
        ldr_done_d      = 1'b0;
        rdata_d         = rdata;
        sram_ce_n_d     = sram_ce_n;
        sram_oe_n_d     = sram_oe_n;
        sram_we_n_d     = sram_we_n;
        sram_addr_d     = sram_addr;
        sram_wdata_d    = sram_wdata;
        sram_wdata_en_d = sram_wdata_en;
        busy_d          = busy;
        grant_id_d      = grant_id;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    last_grant_d    = gnt_id;
                    grant_id_d      = gnt_id;
                    owner_we_d      = win_we;
                    sram_addr_d     = win_addr;
                    sram_wdata_d    = win_wdata;
                    sram_ce_n_d     = 1'b0;
                    sram_oe_n_d     = win_we;
                    sram_we_n_d     = ~win_we;
                    sram_wdata_en_d = win_we;
                    busy_d          = 1'b1;
                    cnt_d           = 4'd0;
                    state_d         = ACCESS;
                end
            end

            ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    // Read data is sampled while oe_n is still low at this edge.
                    if (!owner_we_q) begin
                        rdata_d = sram_rdata;
                    end
                    sram_ce_n_d     = 1'b1;
                    sram_oe_n_d     = 1'b1;
                    sram_we_n_d     = 1'b1;
                    sram_wdata_en_d = 1'b0;
                    cpu_done_d      = (last_grant_q == GNT_CPU);
                    ldr_done_d      = (last_grant_q == GNT_LDR);
                    state_d         = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                sram_ce_n_d     = 1'b1;
                sram_oe_n_d     = 1'b1;
                sram_we_n_d     = 1'b1;
                sram_wdata_en_d = 1'b0;
                busy_d          = 1'b0;
                state_d         = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access without a done.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            last_grant_q  <= GNT_LDR;
            owner_we_q    <= 1'b0;
            cpu_done      <= 1'b0;
            ldr_done      <= 1'b0;
            rdata         <= '0;
            sram_ce_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            sram_we_n     <= 1'b1;
            sram_addr     <= '0;
            sram_wdata    <= '0;
            sram_wdata_en <= 1'b0;
            busy          <= 1'b0;
            grant_id      <= GNT_LDR;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_grant_q  <= last_grant_d;
            owner_we_q    <= owner_we_d;
            cpu_done      <= cpu_done_d;
            ldr_done      <= ldr_done_d;
            rdata         <= rdata_d;
            sram_ce_n     <= sram_ce_n_d;
            sram_oe_n     <= sram_oe_n_d;
            sram_we_n     <= sram_we_n_d;
            sram_addr     <= sram_addr_d;
            sram_wdata    <= sram_wdata_d;
            sram_wdata_en <= sram_wdata_en_d;
            busy          <= busy_d;
            grant_id      <= grant_id_d;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a default build (3-cycle access) driven by
// a vector table and corner-case sequences, plus a 1-cycle build with a
// random handshake run.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;

    logic        cpu_req, cpu_we, ldr_req, ldr_we;
    logic [19:0] cpu_addr, ldr_addr;
    logic [15:0] cpu_wdata, ldr_wdata;
    logic        cpu_done, ldr_done;
    logic [15:0] rdata;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_wdata_en;
    logic [19:0] sram_addr;
    logic [15:0] sram_wdata, sram_rdata;
    logic        busy, grant_id;

    logic        s_cpu_req, s_cpu_we, s_ldr_req, s_ldr_we;
    logic [19:0] s_cpu_addr, s_ldr_addr;
    logic [15:0] s_cpu_wdata, s_ldr_wdata;
    logic        s_cpu_done, s_ldr_done;
    logic [15:0] s_rdata;
    logic        s_ce_n, s_oe_n, s_we_n, s_wdata_en;
    logic [19:0] s_addr;
    logic [15:0] s_wdata, s_sram_rdata;
    logic        s_busy, s_grant_id;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    // SRAM contents model: one fixed word, everything else derived from the address.
    function automatic logic [15:0] mem_model(input logic [19:0] a);
        if (a == 20'h00012) return 16'hBEEF;
        return a[15:0] ^ 16'hA5A5;
    endfunction

    assign sram_rdata   = sram_oe_n ? 16'h0000 : mem_model(sram_addr);
    assign s_sram_rdata = s_oe_n    ? 16'h0000 : mem_model(s_addr);

    sram_arbiter #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYCLES(3)) dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_done(cpu_done),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_done(ldr_done),
        .rdata(rdata),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wdata_en(sram_wdata_en),
        .sram_rdata(sram_rdata),
        .busy(busy), .grant_id(grant_id)
    );

    sram_arbiter #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYCLES(1)) dut1 (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(s_cpu_req), .cpu_we(s_cpu_we), .cpu_addr(s_cpu_addr), .cpu_wdata(s_cpu_wdata), .cpu_done(s_cpu_done),
        .ldr_req(s_ldr_req), .ldr_we(s_ldr_we), .ldr_addr(s_ldr_addr), .ldr_wdata(s_ldr_wdata), .ldr_done(s_ldr_done),
        .rdata(s_rdata),
        .sram_ce_n(s_ce_n), .sram_oe_n(s_oe_n), .sram_we_n(s_we_n),
        .sram_addr(s_addr), .sram_wdata(s_wdata), .sram_wdata_en(s_wdata_en),
        .sram_rdata(s_sram_rdata),
        .busy(s_busy), .grant_id(s_grant_id)
    );

    typedef struct {
        logic        who;
        logic        we;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        int          exp_oe;
        int          exp_we;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // One complete access on the 3-cycle build, watching strobes every cycle.
    task automatic run_access(input logic who, input logic we, input logic [19:0] addr,
                              input logic [15:0] wd, output int oe_cyc, output int we_cyc,
                              output int done_cyc, output int bad, output logic gid);
        oe_cyc = 0; we_cyc = 0; done_cyc = 0; bad = 0; gid = 1'bx;
        @(negedge Clk);
        if (who == GNT_CPU) begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        end else begin
            ldr_req = 1'b1; ldr_we = we; ldr_addr = addr; ldr_wdata = wd;
        end
        for (int c = 1; c <= 20; c++) begin
            @(negedge Clk);
            if (c == 1) gid = grant_id;
            if (!sram_oe_n) oe_cyc++;
            if (!sram_we_n) begin
                we_cyc++;
                if (sram_wdata !== wd || sram_wdata_en !== 1'b1) bad++;
            end
            if (sram_wdata_en && sram_we_n) bad++;
            if (!sram_ce_n && sram_addr !== addr) bad++;
            if (who ? cpu_done : ldr_done) bad++;
            if (who ? ldr_done : cpu_done) begin
                done_cyc = c;
                break;
            end
        end
        cpu_req = 1'b0;
        ldr_req = 1'b0;
    endtask

    int          oe_c, we_c, dc, bad, ng, cpu_dc, ldr_dc, dn;
    logic        gid, prev_busy;
    logic [1:0]  gseq[8];
    logic [15:0] rd_at_cpu;
    int          done_total, overlap, rd_bad, stray;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{GNT_CPU, 1'b0, 20'h00012, 16'h0000, 16'hBEEF, 3, 0};
        vecs[1] = '{GNT_LDR, 1'b1, 20'h00100, 16'h1234, 16'hBEEF, 0, 3};
        vecs[2] = '{GNT_LDR, 1'b0, 20'h00200, 16'h0000, 16'hA7A5, 3, 0};
        vecs[3] = '{GNT_CPU, 1'b1, 20'h00300, 16'hCAFE, 16'hA7A5, 0, 3};
        vecs[4] = '{GNT_CPU, 1'b0, 20'h00045, 16'h0000, 16'hA5E0, 3, 0};

        Reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
        s_cpu_req = 0; s_cpu_we = 0; s_cpu_addr = '0; s_cpu_wdata = '0;
        s_ldr_req = 0; s_ldr_we = 0; s_ldr_addr = '0; s_ldr_wdata = '0;
        do_reset();

        // Reset values
        @(negedge Clk);
        check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_wdata_en}, 4'b1110);
        check("rst_addr_wdata", {sram_addr, sram_wdata}, 36'h0);
        check("rst_rdata", rdata, 16'h0);
        check("rst_status", {cpu_done, ldr_done, busy, grant_id}, 4'b0001);

        // Table of single accesses
        for (int i = 0; i < 5; i++) begin
            run_access(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wdata, oe_c, we_c, dc, bad, gid);
            check($sformatf("v%0d_oe_cycles", i), oe_c, vecs[i].exp_oe);
            check($sformatf("v%0d_we_cycles", i), we_c, vecs[i].exp_we);
            check($sformatf("v%0d_done_cycle", i), dc, 4);
            check($sformatf("v%0d_bus_errors", i), bad, 0);
            check($sformatf("v%0d_grant_id", i), gid, vecs[i].who);
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
        end

        // Simultaneous requests right after reset: cpu wins the first tie
        do_reset();
        @(negedge Clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00012;
        ldr_req = 1; ldr_we = 1; ldr_addr = 20'h00100; ldr_wdata = 16'h5555;
        ng = 0; cpu_dc = 0; ldr_dc = 0; prev_busy = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge Clk);
            if (busy && !prev_busy && ng < 8) begin gseq[ng] = {1'b0, grant_id}; ng++; end
            prev_busy = busy;
            if (cpu_done && cpu_req) begin cpu_dc = c; cpu_req = 0; end
            if (ldr_done && ldr_req) begin ldr_dc = c; ldr_req = 0; end
        end
        check("tie_grant_count", ng, 2);
        check("tie_first_grant", gseq[0], 2'd0);
        check("tie_second_grant", gseq[1], 2'd1);
        check("tie_cpu_done_cycle", cpu_dc, 4);
        check("tie_ldr_done_cycle", ldr_dc, 9);

        // Loader streams back-to-back; cpu arrives mid-access and must win next
        do_reset();
        @(negedge Clk);
        ldr_req = 1; ldr_we = 0; ldr_addr = 20'h00200;
        ng = 0; cpu_dc = 0; prev_busy = 0; rd_at_cpu = '0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge Clk);
            if (busy && !prev_busy && ng < 8) begin gseq[ng] = {1'b0, grant_id}; ng++; end
            prev_busy = busy;
            if (cpu_done && cpu_req) begin cpu_dc = c; rd_at_cpu = rdata; cpu_req = 0; end
            if (c == 7) begin cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00045; end
        end
        ldr_req = 0;
        check("rr_grant_count", ng, 5);
        check("rr_grant_seq", {gseq[0], gseq[1], gseq[2], gseq[3], gseq[4]}, 10'b01_01_00_01_01);
        check("rr_cpu_done_cycle", cpu_dc, 14);
        check("rr_cpu_rdata", rd_at_cpu, 16'hA5E0);

        // Reset during ACCESS at cnt=1 aborts without a done
        do_reset();
        @(negedge Clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00045;
        @(negedge Clk);
        @(negedge Clk);
        check("abort_pre_oe", {sram_ce_n, sram_oe_n, busy}, 3'b001);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        cpu_req = 0;
        check("abort_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_wdata_en}, 4'b1110);
        check("abort_status", {cpu_done, ldr_done, busy, grant_id}, 4'b0001);
        dn = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge Clk);
            if (cpu_done || ldr_done || busy) dn++;
        end
        check("abort_no_done", dn, 0);
        run_access(GNT_CPU, 1'b0, 20'h00012, 16'h0000, oe_c, we_c, dc, bad, gid);
        check("abort_after_oe", oe_c, 3);
        check("abort_after_done", dc, 4);
        check("abort_after_rdata", rdata, 16'hBEEF);

        // ACCESS_CYCLES=1 build: single read
        @(negedge Clk);
        s_cpu_req = 1; s_cpu_we = 0; s_cpu_addr = 20'h00012;
        oe_c = 0; dc = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge Clk);
            if (!s_oe_n) oe_c++;
            if (s_cpu_done) begin dc = c; break; end
        end
        s_cpu_req = 0;
        check("n1_oe_cycles", oe_c, 1);
        check("n1_done_cycle", dc, 2);
        check("n1_rdata", s_rdata, 16'hBEEF);

        // ACCESS_CYCLES=1 build: random handshake run of 1000 accesses
        done_total = 0; overlap = 0; rd_bad = 0; stray = 0;
        for (int c = 0; c < 8000 && done_total < 1000; c++) begin
            @(negedge Clk);
            if (!s_oe_n && !s_we_n) overlap++;
            if (s_wdata_en && s_we_n) overlap++;
            if (s_cpu_done) begin
                if (!s_cpu_req) stray++;
                else begin
                    if (!s_cpu_we && s_rdata !== mem_model(s_cpu_addr)) rd_bad++;
                    done_total++;
                    s_cpu_req = 0;
                end
            end else if (!s_cpu_req && $urandom_range(0, 1) == 1) begin
                s_cpu_req = 1; s_cpu_we = 1'($urandom_range(0, 1));
                s_cpu_addr = 20'($urandom_range(0, 20'hFFFFF)); s_cpu_wdata = 16'($urandom);
            end
            if (s_ldr_done) begin
                if (!s_ldr_req) stray++;
                else begin
                    if (!s_ldr_we && s_rdata !== mem_model(s_ldr_addr)) rd_bad++;
                    done_total++;
                    s_ldr_req = 0;
                end
            end else if (!s_ldr_req && $urandom_range(0, 1) == 1) begin
                s_ldr_req = 1; s_ldr_we = 1'($urandom_range(0, 1));
                s_ldr_addr = 20'($urandom_range(0, 20'hFFFFF)); s_ldr_wdata = 16'($urandom);
            end
        end
        s_cpu_req = 0;
        s_ldr_req = 0;
        check("rand_completed", done_total, 1000);
        check("rand_overlap", overlap, 0);
        check("rand_read_data", rd_bad, 0);
        check("rand_stray_done", stray, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
